// File: rtl/mdu_sched_if.sv
// Decoder <-> MDU sequencer handshake bundle.
// master: decoder/hazard side; slave: mdu_sched.
interface mdu_sched_if;
    logic       start_E;
    logic [2:0] op_E;
    logic       md_D;
    logic       op_latch;
    logic       is_signed;
    logic [1:0] hilo_src;
    logic       hi_we;
    logic       lo_we;
    logic       busy;
    logic       stall_D;

    modport master (
        output start_E,
        output op_E,
        output md_D,
        input  op_latch,
        input  is_signed,
        input  hilo_src,
        input  hi_we,
        input  lo_we,
        input  busy,
        input  stall_D
    );

    modport slave (
        input  start_E,
        input  op_E,
        input  md_D,
        output op_latch,
        output is_signed,
        output hilo_src,
        output hi_we,
        output lo_we,
        output busy,
        output stall_D
    );
endinterface

// File: rtl/mdu_sched.sv
// MDU sequencer: latency counting, HI/LO write strobes and D-stage stall.
// Optional macro MDU_STALL_STATS_EN adds a 32-bit stall cycle counter.
module mdu_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  bus
`ifdef MDU_STALL_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DIV  = 2'b10;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;

    logic w_idle;
    logic w_run;
    logic w_is_mul;
    logic w_is_div;
    logic w_iss_mul;
    logic w_iss_div;
    logic w_issue;
    logic w_mtlo;
    logic w_mthi;
    logic w_done;
    logic w_md_op;
    logic w_sgn_e;
    logic w_sgn_q;

    assign w_idle   = (r_state == S_IDLE);
    assign w_run    = ~w_idle;
    assign w_is_mul = (bus.op_E == OP_MULT) | (bus.op_E == OP_MULTU);
    assign w_is_div = (bus.op_E == OP_DIV) | (bus.op_E == OP_DIVU);

    // Starts and moves are only honoured from IDLE; anything else is ignored.
    assign w_iss_mul = w_idle & bus.start_E & w_is_mul;
    assign w_iss_div = w_idle & bus.start_E & w_is_div;
    assign w_issue   = w_iss_mul | w_iss_div;
    assign w_mtlo    = w_idle & bus.start_E & (bus.op_E == OP_MTLO);
    assign w_mthi    = w_idle & bus.start_E & (bus.op_E == OP_MTHI);
    assign w_done    = w_run & (r_cnt == '0);

    assign w_md_op = bus.start_E & (w_is_mul | w_is_div);
    assign w_sgn_e = (bus.op_E == OP_MULT) | (bus.op_E == OP_DIV);
    assign w_sgn_q = (r_op == OP_MULT) | (r_op == OP_DIV);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_iss_mul) begin
                        r_state <= S_MUL;
                        r_cnt   <= MUL_INIT;
                        r_op    <= bus.op_E;
                    end else if (w_iss_div) begin
                        r_state <= S_DIV;
                        r_cnt   <= DIV_INIT;
                        r_op    <= bus.op_E;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Every output is held low while reset is asserted.
    always_comb begin
        bus.op_latch  = 1'b0;
        bus.is_signed = 1'b0;
        bus.hilo_src  = 2'd0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.busy      = 1'b0;
        bus.stall_D   = 1'b0;
        if (!reset) begin
            bus.op_latch = w_issue;
            bus.busy     = w_run;
            bus.stall_D  = bus.md_D & (w_run | w_md_op);
            bus.hi_we    = w_done | w_mthi;
            bus.lo_we    = w_done | w_mtlo;
            unique case (1'b1)
                w_issue: bus.is_signed = w_sgn_e;
                w_run:   bus.is_signed = w_sgn_q;
                default: bus.is_signed = 1'b0;
            endcase
            unique case (1'b1)
                w_done:          bus.hilo_src = (r_state == S_DIV) ? 2'd1 : 2'd0;
                w_mtlo | w_mthi: bus.hilo_src = 2'd2;
                default:         bus.hilo_src = 2'd0;
            endcase
        end
    end

`ifdef MDU_STALL_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.stall_D) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched with default latencies (MUL 5, DIV 10).
// Build with MDU_STALL_STATS_EN defined to also exercise the stall counter.
module tb_mdu_sched;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mdu_sched_if u_if ();

`ifdef MDU_STALL_STATS_EN
    logic [31:0] stall_cnt;
`endif

    mdu_sched #(
        .MUL_LAT (5),
        .DIV_LAT (10),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
`ifdef MDU_STALL_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one cycle; returns mid-cycle, away from the edge.
    task automatic drive(input logic s, input logic [2:0] op,
                         input logic md, input logic rst);
        @(posedge clk);
        #1;
        u_if.start_E = s;
        u_if.op_E    = op;
        u_if.md_D    = md;
        reset        = rst;
        #3;
    endtask

    task automatic test_reset;
        drive(1'b1, 3'b001, 1'b1, 1'b1);
        checks++;
        if (u_if.op_latch !== 1'b0 || u_if.is_signed !== 1'b0 ||
            u_if.hi_we !== 1'b0 || u_if.lo_we !== 1'b0 ||
            u_if.busy !== 1'b0 || u_if.stall_D !== 1'b0 ||
            u_if.hilo_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_mult: got latch=%b sgn=%b hi=%b lo=%b busy=%b stall=%b src=%0d want all 0",
                     u_if.op_latch, u_if.is_signed, u_if.hi_we, u_if.lo_we,
                     u_if.busy, u_if.stall_D, u_if.hilo_src);
        end
        drive(1'b1, 3'b110, 1'b1, 1'b1);
        checks++;
        if (u_if.hi_we !== 1'b0 || u_if.hilo_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_mthi: got hi=%b src=%0d want 0 0",
                     u_if.hi_we, u_if.hilo_src);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.op_latch !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b latch=%b want 0 0",
                     u_if.busy, u_if.op_latch);
        end
    endtask

    task automatic test_mult;
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        checks++;
        if (u_if.op_latch !== 1'b1 || u_if.is_signed !== 1'b1 ||
            u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_issue: got latch=%b sgn=%b busy=%b want 1 1 0",
                     u_if.op_latch, u_if.is_signed, u_if.busy);
        end
        for (int c = 1; c <= 5; c++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0);
            checks++;
            if (u_if.busy !== 1'b1 || u_if.op_latch !== 1'b0) begin
                errors++;
                $display("FAIL mult_busy c%0d: got busy=%b latch=%b want 1 0",
                         c, u_if.busy, u_if.op_latch);
            end
            checks++;
            if (c == 5) begin
                if (u_if.hi_we !== 1'b1 || u_if.lo_we !== 1'b1 ||
                    u_if.hilo_src !== 2'd0) begin
                    errors++;
                    $display("FAIL mult_write: got hi=%b lo=%b src=%0d want 1 1 0",
                             u_if.hi_we, u_if.lo_we, u_if.hilo_src);
                end
            end else if (u_if.hi_we !== 1'b0 || u_if.lo_we !== 1'b0) begin
                errors++;
                $display("FAIL mult_early c%0d: got hi=%b lo=%b want 0 0",
                         c, u_if.hi_we, u_if.lo_we);
            end
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.hi_we !== 1'b0) begin
            errors++;
            $display("FAIL mult_done: got busy=%b hi=%b want 0 0",
                     u_if.busy, u_if.hi_we);
        end
    endtask

    task automatic test_divu_stall;
        for (int c = 0; c <= 10; c++) begin
            drive(c == 0, (c == 0) ? 3'b100 : 3'b000, 1'b1, 1'b0);
            checks++;
            if (u_if.stall_D !== 1'b1) begin
                errors++;
                $display("FAIL divu_stall c%0d: got %b want 1", c, u_if.stall_D);
            end
            if (c == 10) begin
                checks++;
                if (u_if.hi_we !== 1'b1 || u_if.lo_we !== 1'b1 ||
                    u_if.hilo_src !== 2'd1 || u_if.is_signed !== 1'b0) begin
                    errors++;
                    $display("FAIL divu_write: got hi=%b lo=%b src=%0d sgn=%b want 1 1 1 0",
                             u_if.hi_we, u_if.lo_we, u_if.hilo_src, u_if.is_signed);
                end
            end
        end
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        checks++;
        if (u_if.stall_D !== 1'b0 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL divu_release: got stall=%b busy=%b want 0 0",
                     u_if.stall_D, u_if.busy);
        end
    endtask

    task automatic test_move;
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        checks++;
        if (u_if.hi_we !== 1'b1 || u_if.lo_we !== 1'b0 ||
            u_if.hilo_src !== 2'd2 || u_if.busy !== 1'b0 ||
            u_if.op_latch !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%b lo=%b src=%0d busy=%b latch=%b want 1 0 2 0 0",
                     u_if.hi_we, u_if.lo_we, u_if.hilo_src, u_if.busy, u_if.op_latch);
        end
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        checks++;
        if (u_if.stall_D !== 1'b0 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi_nostall: got stall=%b busy=%b want 0 0",
                     u_if.stall_D, u_if.busy);
        end
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        checks++;
        if (u_if.lo_we !== 1'b1 || u_if.hi_we !== 1'b0 ||
            u_if.hilo_src !== 2'd2) begin
            errors++;
            $display("FAIL mtlo: got lo=%b hi=%b src=%0d want 1 0 2",
                     u_if.lo_we, u_if.hi_we, u_if.hilo_src);
        end
        drive(1'b1, 3'b111, 1'b1, 1'b0);
        checks++;
        if (u_if.hi_we !== 1'b0 || u_if.lo_we !== 1'b0 ||
            u_if.op_latch !== 1'b0 || u_if.stall_D !== 1'b0) begin
            errors++;
            $display("FAIL op111: got hi=%b lo=%b latch=%b stall=%b want 0 0 0 0",
                     u_if.hi_we, u_if.lo_we, u_if.op_latch, u_if.stall_D);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        checks++;
        if (u_if.op_latch !== 1'b1 || u_if.is_signed !== 1'b1) begin
            errors++;
            $display("FAIL div_issue: got latch=%b sgn=%b want 1 1",
                     u_if.op_latch, u_if.is_signed);
        end
        for (int c = 1; c <= 3; c++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0);
            checks++;
            if (u_if.busy !== 1'b1 || u_if.is_signed !== 1'b1) begin
                errors++;
                $display("FAIL div_busy c%0d: got busy=%b sgn=%b want 1 1",
                         c, u_if.busy, u_if.is_signed);
            end
        end
        drive(1'b0, 3'b000, 1'b1, 1'b1);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.stall_D !== 1'b0 ||
            u_if.is_signed !== 1'b0 || u_if.hi_we !== 1'b0 ||
            u_if.lo_we !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: got busy=%b stall=%b sgn=%b hi=%b lo=%b want all 0",
                     u_if.busy, u_if.stall_D, u_if.is_signed, u_if.hi_we, u_if.lo_we);
        end
        for (int c = 5; c <= 11; c++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0);
            checks++;
            if (u_if.busy !== 1'b0 || u_if.hi_we !== 1'b0 ||
                u_if.lo_we !== 1'b0) begin
                errors++;
                $display("FAIL midreset_after c%0d: got busy=%b hi=%b lo=%b want 0 0 0",
                         c, u_if.busy, u_if.hi_we, u_if.lo_we);
            end
        end
    endtask

    task automatic test_busy_ignore;
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        checks++;
        if (u_if.op_latch !== 1'b1 || u_if.is_signed !== 1'b0) begin
            errors++;
            $display("FAIL multu_issue: got latch=%b sgn=%b want 1 0",
                     u_if.op_latch, u_if.is_signed);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        checks++;
        if (u_if.op_latch !== 1'b0 || u_if.hi_we !== 1'b0 ||
            u_if.is_signed !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: got latch=%b hi=%b sgn=%b want 0 0 0",
                     u_if.op_latch, u_if.hi_we, u_if.is_signed);
        end
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        checks++;
        if (u_if.lo_we !== 1'b0 || u_if.hilo_src !== 2'd0) begin
            errors++;
            $display("FAIL busy_mtlo: got lo=%b src=%0d want 0 0",
                     u_if.lo_we, u_if.hilo_src);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (u_if.hi_we !== 1'b1 || u_if.lo_we !== 1'b1 ||
            u_if.hilo_src !== 2'd0) begin
            errors++;
            $display("FAIL busy_write: got hi=%b lo=%b src=%0d want 1 1 0",
                     u_if.hi_we, u_if.lo_we, u_if.hilo_src);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: got busy=%b want 0", u_if.busy);
        end
    endtask

`ifdef MDU_STALL_STATS_EN
    task automatic test_stall_stats;
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_init: got %0d want 0", stall_cnt);
        end
        for (int c = 0; c <= 10; c++) begin
            drive(c == 0, (c == 0) ? 3'b100 : 3'b000, 1'b1, 1'b0);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd11) begin
            errors++;
            $display("FAIL stats_count: got %0d want 11", stall_cnt);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear: got %0d want 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        u_if.start_E = 1'b0;
        u_if.op_E    = 3'b000;
        u_if.md_D    = 1'b0;
        test_reset();
        test_mult();
        test_divu_stall();
        test_move();
        test_reset_mid();
        test_busy_ignore();
`ifdef MDU_STALL_STATS_EN
        test_stall_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
